// File: rtl/aes_mix_columns_seq_pkg.sv
// Shared AES helpers: direction constants, FSM state type, GF(2^8) multiplies
// and column extract/insert for the 128-bit state (byte (r,c) at bits [(4r+c)*8 +: 8]).
package aes_mix_columns_seq_pkg;

  localparam logic CIPH_FWD = 1'b0;
  localparam logic CIPH_INV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } mc_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] aes_mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_mul3(input logic [7:0] x);
    return aes_mul2(x) ^ x;
  endfunction

  function automatic logic [7:0] aes_mul4(input logic [7:0] x);
    return aes_mul2(aes_mul2(x));
  endfunction

  // Column as {a3, a2, a1, a0}, with a0 (row 0) in the low byte.
  function automatic logic [31:0] aes_col_get(input logic [127:0] s,
                                              input logic [1:0]   c);
    logic [31:0] col;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      col[r*8 +: 8] = s[(4*r + int'(c))*8 +: 8];
    end
    return col;
  endfunction

  function automatic logic [127:0] aes_col_set(input logic [127:0] s,
                                               input logic [1:0]   c,
                                               input logic [31:0]  col);
    logic [127:0] res;
    res = s;
    for (int r = 0; r < 4; r++) begin
      res[(4*r + int'(c))*8 +: 8] = col[r*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_mix_columns_seq_mix.sv
// aes_mix_single_column: combinational MixColumns / InvMixColumns on one 32-bit
// column. The inverse is a 04-multiple pre-add followed by the forward matrix.
module aes_mix_single_column
  import aes_mix_columns_seq_pkg::*;
(
  input  logic        op,
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] u, v;
  logic [7:0] p0, p1, p2, p3;

  assign a0 = col[7:0];
  assign a1 = col[15:8];
  assign a2 = col[23:16];
  assign a3 = col[31:24];

  // InvMix = Mix * {05 00 04 00} rotated, so the inverse only adds 4*(a0^a2)
  // and 4*(a1^a3) ahead of the shared forward network.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    u = 8'h00;
    v = 8'h00;
    if (op == CIPH_INV) begin
      u = aes_mul4(a0 ^ a2);
      v = aes_mul4(a1 ^ a3);
    end
  end

  assign p0 = a0 ^ u;
  assign p1 = a1 ^ v;
  assign p2 = a2 ^ u;
  assign p3 = a3 ^ v;

  assign mixed[7:0]   = aes_mul2(p0) ^ aes_mul3(p1) ^ p2           ^ p3;
  assign mixed[15:8]  = p0           ^ aes_mul2(p1) ^ aes_mul3(p2) ^ p3;
  assign mixed[23:16] = p0           ^ p1           ^ aes_mul2(p2) ^ aes_mul3(p3);
  assign mixed[31:24] = aes_mul3(p0) ^ p1           ^ p2           ^ aes_mul2(p3);

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequential AES (Inv)MixColumns over a 128-bit state with valid/ready on both sides.
// Define AES_MIX_COLUMNS_2COL_EN to process two columns per cycle (2-cycle latency).
module aes_mix_columns_seq
  import aes_mix_columns_seq_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         op_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

`ifdef AES_MIX_COLUMNS_2COL_EN
  localparam logic [1:0] CNT_STEP = 2'd2;
  localparam logic [1:0] CNT_LAST = 2'd2;
`else
  localparam logic [1:0] CNT_STEP = 2'd1;
  localparam logic [1:0] CNT_LAST = 2'd3;
`endif

  mc_state_e    state_q;
  logic [1:0]   cnt_q;
  logic [127:0] data_q;
  logic         op_q;
  logic [127:0] data_next;
  logic [31:0]  col_a, mixed_a;

  assign col_a = aes_col_get(data_q, cnt_q);

  aes_mix_single_column u_mix_a (
    .op    (op_q),
    .col   (col_a),
    .mixed (mixed_a)
  );

`ifdef AES_MIX_COLUMNS_2COL_EN
  logic [1:0]  cnt_b;
  logic [31:0] col_b, mixed_b;

  assign cnt_b = cnt_q + 2'd1;
  assign col_b = aes_col_get(data_q, cnt_b);

  aes_mix_single_column u_mix_b (
    .op    (op_q),
    .col   (col_b),
    .mixed (mixed_b)
  );

  assign data_next = aes_col_set(aes_col_set(data_q, cnt_q, mixed_a), cnt_b, mixed_b);
`else
  assign data_next = aes_col_set(data_q, cnt_q, mixed_a);
`endif

  // The working register holds partial columns during COMPUTE; mask it out.
  assign data_o = out_valid_o ? data_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the 128-bit state register is reset as well, because data_o must
  // read 0 from reset and a discarded result must never leak out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      op_q        <= CIPH_FWD;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            data_q     <= data_i;
            op_q       <= op_i;
            cnt_q      <= '0;
            state_q    <= ST_COMPUTE;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        ST_COMPUTE: begin
          data_q <= data_next;
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            out_valid_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_STEP;
          end
        end
        ST_DONE: begin
          // Return to IDLE only; acceptance waits for the next cycle.
          if (out_ready_i) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          data_q      <= '0;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Directed bench for aes_mix_columns_seq: known MixColumns vectors, inverse
// round trips, output stall, mid-COMPUTE reset and back-to-back throughput.
module tb_aes_mix_columns_seq;
  import aes_mix_columns_seq_pkg::*;

`ifdef AES_MIX_COLUMNS_2COL_EN
  localparam int LAT    = 2;
  localparam int PERIOD = 4;
`else
  localparam int LAT    = 4;
  localparam int PERIOD = 6;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         op_i = CIPH_FWD;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [127:0] data_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [127:0] data_o;
  logic         busy_o;

  int n_checks = 0;
  int n_errors = 0;

  aes_mix_columns_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .op_i        (op_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .busy_o      (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Columns written {row0,row1,row2,row3}, row0 in the top byte.
  function automatic logic [127:0] pack(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0]  cols [4];
    logic [127:0] s;
    cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[(4*r + c)*8 +: 8] = cols[c][(3-r)*8 +: 8];
    return s;
  endfunction

  // One transaction from IDLE; hold > 0 stalls in DONE and pokes in_valid_i.
  task automatic transact(input logic op, input logic [127:0] d, input logic chk,
                          input logic [127:0] exp, input int hold, input string tag,
                          output logic [127:0] res);
    int cyc;
    check({tag, " ready"}, in_ready_o, 1'b1);
    op_i = op; data_i = d; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; op_i = ~op; data_i = ~d;
    check({tag, " busy"}, busy_o, 1'b1);
    check({tag, " not ready"}, in_ready_o, 1'b0);
    cyc = 0;
    while (!out_valid_o && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, LAT);
    res = data_o;
    if (chk) check({tag, " data"}, data_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      in_valid_i = (i == 2);
      data_i = {4{$urandom}};
      check({tag, " stall data"}, data_o, res);
      check({tag, " stall ready"}, in_ready_o, 1'b0);
      check({tag, " stall valid"}, out_valid_o, 1'b1);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    check({tag, " out cleared"}, data_o, '0);
    check({tag, " valid low"}, out_valid_o, 1'b0);
    check({tag, " ready back"}, in_ready_o, 1'b1);
    check({tag, " idle"}, busy_o, 1'b0);
  endtask

  logic [127:0] a_in, a_out, b_in, b_out, r_in, r_mid, res;

  initial begin
    int seen, cyc, n_res, t_prev;
    a_in  = pack(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
    a_out = pack(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
    b_in  = pack(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5);
    b_out = pack(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6);
    r_in  = {$urandom, $urandom, $urandom, $urandom};

    #12;
    check("reset in_ready", in_ready_o, 1'b1);
    check("reset out_valid", out_valid_o, 1'b0);
    check("reset busy", busy_o, 1'b0);
    check("reset data_o", data_o, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    transact(CIPH_FWD, a_in,  1'b1, a_out, 0, "fwd A", res);
    transact(CIPH_FWD, b_in,  1'b1, b_out, 0, "fwd B", res);
    transact(CIPH_INV, b_out, 1'b1, b_in,  0, "inv B", res);
    transact(CIPH_INV, a_out, 1'b1, a_in,  0, "inv A", res);
    transact(CIPH_FWD, r_in,  1'b0, '0,    0, "fwd R", r_mid);
    transact(CIPH_INV, r_mid, 1'b1, r_in,  0, "inv R", res);

    // Stall in DONE for 10 cycles; the extra input must not be queued.
    transact(CIPH_FWD, b_in, 1'b1, b_out, 10, "stall", res);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (out_valid_o || busy_o) seen++;
    end
    check("stall no queued job", seen, 0);

    // Reset in the second COMPUTE cycle aborts the job.
    op_i = CIPH_FWD; data_i = a_in; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    check("abort in_ready", in_ready_o, 1'b1);
    check("abort out_valid", out_valid_o, 1'b0);
    check("abort busy", busy_o, 1'b0);
    check("abort data_o", data_o, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen++;
    end
    check("abort no valid pulse", seen, 0);
    transact(CIPH_FWD, b_in, 1'b1, b_out, 0, "after abort", res);

    // Back-to-back with out_ready_i high throughout; op_i/data_i wiggle mid-job.
    out_ready_i = 1'b1; in_valid_i = 1'b1; op_i = CIPH_FWD; data_i = a_in;
    n_res = 0; cyc = 0; t_prev = 0;
    while (n_res < 3 && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
      if (out_valid_o) begin
        check("b2b data", data_o, a_out);
        if (n_res == 0) check("b2b first", cyc, 1 + LAT);
        else            check("b2b period", cyc - t_prev, PERIOD);
        t_prev = cyc;
        n_res++;
      end
      op_i   = in_ready_o ? CIPH_FWD : ~op_i;
      data_i = in_ready_o ? a_in : ~data_i;
    end
    check("b2b count", n_res, 3);
    in_valid_i = 1'b0;
    repeat (8) @(posedge clk_i);
    out_ready_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_seq.md
AES_MIX_COLUMNS_SEQ -- requirements
Module: aes_mix_columns_seq

Interface
REQ-001 The block SHALL have parameter-free ports, with clock and reset listed first:
REQ-002 clk_i  input  1  block clock; all state SHALL change on the rising edge only.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 op_i  input  1  direction (CIPH_FWD=1'b0 MixColumns, CIPH_INV=1'b1 InvMixColumns); sampled at input handshake.
REQ-005 in_valid_i  input  1  data_i/op_i valid.
REQ-006 in_ready_o  output  1  block can accept a state.
REQ-007 data_i  input  128  state; byte (row r, col c) at bits [(4r+c)*8 +: 8].
REQ-008 out_valid_o  output  1  data_o holds a result.
REQ-009 out_ready_i  input  1  consumer accepts the result.
REQ-010 data_o  output  128  result, same byte layout as data_i.
REQ-011 busy_o  output  1  high in COMPUTE or DONE.

Function
REQ-012 The FSM SHALL have the states IDLE, COMPUTE and DONE.
REQ-013 in_ready_o SHALL be 1 only in IDLE, and an input handshake SHALL be in_valid_i&in_ready_o.
REQ-014 On an input handshake the block SHALL latch data_i and op_i into internal registers, clear the column counter to 0, and go to COMPUTE.
REQ-015 Each COMPUTE cycle SHALL replace column cnt (4 bytes a0..a3, rows 0..3) in the state register with its GF(2^8) product, using the polynomial x^8+x^4+x^3+x+1.
REQ-016 In forward mode the product SHALL use the matrix rows {02 03 01 01} rotated per row.
REQ-017 In inverse mode the product SHALL use the matrix rows {0e 0b 0d 09} rotated per row.
REQ-018 After column 3 the FSM SHALL go to DONE, and out_valid_o SHALL rise exactly 4 cycles after the input handshake edge.
REQ-019 In DONE, out_valid_o SHALL be 1 and data_o SHALL hold stable until out_ready_i is 1.
REQ-020 On the output handshake the FSM SHALL go to IDLE and the state register SHALL be zeroed in the same edge.
REQ-021 data_o SHALL read 0 whenever out_valid_o is 0.
REQ-022 in_valid_i asserted outside IDLE SHALL be ignored; the block SHALL NOT queue it.
REQ-023 There SHALL be no same-cycle output-to-input bypass, so a new acceptance happens at the earliest one cycle after the output handshake.
REQ-024 out_ready_i held high before DONE SHALL have no effect.
REQ-025 A change of op_i or data_i during COMPUTE SHALL NOT alter the result.

Reset
REQ-026 While rst_i=1 the block SHALL hold state=IDLE, cnt=0, data register=0 and op register=CIPH_FWD.
REQ-027 The reset values of the outputs SHALL be in_ready_o=1, out_valid_o=0, busy_o=0 and data_o=0.
REQ-028 Reset asserted mid-COMPUTE or in DONE SHALL abort immediately, the result SHALL be discarded and no out_valid_o pulse SHALL occur.

Configuration
REQ-029 Macro AES_MIX_COLUMNS_2COL_EN SHALL select the processing rate.
REQ-030 When AES_MIX_COLUMNS_2COL_EN is defined, two columns (cnt, cnt+1) SHALL be processed per COMPUTE cycle and out_valid_o SHALL rise 2 cycles after the handshake.
REQ-031 When AES_MIX_COLUMNS_2COL_EN is undefined, the block SHALL process one column per cycle with 4-cycle latency.
REQ-032 The handshake and reset behaviour SHALL be identical in both builds.

Structure
REQ-033 The constants CIPH_FWD/CIPH_INV SHALL come from the shared AES package.
REQ-034 The helper functions aes_mul2, aes_mul4 and aes_col_get SHALL come from the shared AES package.
REQ-035 A col_set helper SHALL be added to the shared AES package.
REQ-036 One sub-module, aes_mix_single_column, SHALL be used: 32-bit combinational, op-selectable.
REQ-037 aes_mix_single_column SHALL implement the inverse as a 04-multiple pre-add followed by the forward matrix.
REQ-038 aes_mix_columns_seq SHALL instantiate aes_mix_single_column once, or twice when AES_MIX_COLUMNS_2COL_EN is defined.

Verification
REQ-039 Forward, all 4 columns {db,13,53,45} (row0..3) -> every column {8e,4d,a1,bc}; out_valid_o exactly 4 cycles after accept (2 with the macro).
REQ-040 Forward, columns {f2,0a,22,5c},{01,01,01,01},{c6,c6,c6,c6},{d4,d4,d4,d5} -> {9f,dc,58,9d},{01,01,01,01},{c6,c6,c6,c6},{d5,d5,d7,d6}.
REQ-041 Inverse of the REQ-040 outputs -> original inputs; a random 128-bit state forward then inverse -> identity.
REQ-042 Hold out_ready_i=0 for 10 cycles in DONE, pulse in_valid_i with new data -> data_o stable, in_ready_o=0, extra input ignored; then out_ready_i=1 -> data_o=0 next cycle, in_ready_o=1.
REQ-043 Assert rst_i during COMPUTE cycle 2 -> outputs immediately at reset values, no out_valid_o pulse; after release a fresh accept yields the correct result.
REQ-044 Back-to-back: in_valid_i held high with out_ready_i=1 -> one result every 6 cycles (4 with the macro), op_i toggled mid-COMPUTE without effect.
